tetris_key_action: RTL and testbench

- Sits directly downstream of the PS/2 keyboard decoder.
- Consumes its two-slot held-key report (key1_on/key1_code, key2_on/key2_code) and turns it into single-cycle game-action pulses for the Tetris game FSM.
- Applies delayed auto-repeat (DAS/ARR) to left, right and soft-drop, and one-shot semantics to the other keys.
- The decoder runs on PS2_CLK-derived logic, so all inputs are resynchronised into clk here.

---
 rtl/tetris_key_pkg.sv | 46 ++++
 rtl/key_repeat_timer.sv | 94 +++++++++
 rtl/tetris_key_action.sv | 121 ++++++++++++
 tb/tb_tetris_key_action.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_key_pkg.sv
// rtl/tetris_key_pkg.sv - scan codes, held-vector layout, repeat-FSM encoding and slot decoder
package tetris_key_pkg;

    localparam logic [7:0] KEY_UP       = 8'h75;
    localparam logic [7:0] KEY_DOWN     = 8'h72;
    localparam logic [7:0] KEY_LEFT     = 8'h6B;
    localparam logic [7:0] KEY_RIGHT    = 8'h74;
    localparam logic [7:0] KEY_ROTATE   = 8'h12;
    localparam logic [7:0] KEY_L_ROTATE = 8'h1A;
    localparam logic [7:0] KEY_R_ROTATE = 8'h22;
    localparam logic [7:0] KEY_ENTER    = 8'h5A;
    localparam logic [7:0] KEY_RELEASE  = 8'hF0;

    // Bit positions in the 7-bit held/action vector
    localparam int H_LEFT    = 0;
    localparam int H_RIGHT   = 1;
    localparam int H_SOFT    = 2;
    localparam int H_HARD    = 3;
    localparam int H_ROT_CW  = 4;
    localparam int H_ROT_CCW = 5;
    localparam int H_START   = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Maps one synchronised slot {on, code} to the actions it holds.
    // Unknown codes and the release marker decode to nothing.
    function automatic logic [6:0] decode_slot(input logic [8:0] slot);
        logic [6:0] h;
        h = '0;
        if (slot[8]) begin
            h[H_LEFT]    = (slot[7:0] == KEY_LEFT);
            h[H_RIGHT]   = (slot[7:0] == KEY_RIGHT);
            h[H_SOFT]    = (slot[7:0] == KEY_DOWN);
            h[H_HARD]    = (slot[7:0] == KEY_UP);
            h[H_ROT_CW]  = (slot[7:0] == KEY_ROTATE) || (slot[7:0] == KEY_R_ROTATE);
            h[H_ROT_CCW] = (slot[7:0] == KEY_L_ROTATE);
            h[H_START]   = (slot[7:0] == KEY_ENTER);
        end
        return h;
    endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// rtl/key_repeat_timer.sv - delayed auto-repeat (DAS/ARR) pulse generator for one held key
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   held  - decoded key-held level
//   en    - when low the FSM is forced to IDLE and emits nothing
//   pulse - registered single-cycle action pulse
// Pulse offsets from the first pulse: 0, DAS, DAS+ARR, DAS+2*ARR, ...
module key_repeat_timer
    import tetris_key_pkg::*;
#(
    parameter int DAS_CYCLES = 20,
    parameter int ARR_CYCLES = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic held,
    input  logic en,
    output logic pulse
);

    localparam int MAX_CYCLES = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DAS_LOAD = CW'(DAS_CYCLES - 1);
    localparam logic [CW-1:0] ARR_LOAD = CW'(ARR_CYCLES - 1);

    rpt_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          held_q;
    logic          pulse_n;

    // held_q tracks the key even while disabled, so a key held through a
    // disabled period must be released and pressed again to fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            held_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            held_q <= held;
            pulse  <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (held && !held_q) begin
                        pulse_n = 1'b1;
                        cnt_n   = DAS_LOAD;
                        state_n = DELAY;
                    end
                end
                DELAY: begin
                    if (!held) begin
                        state_n = IDLE;
                    end else if (cnt == '0) begin
                        pulse_n = 1'b1;
                        cnt_n   = ARR_LOAD;
                        state_n = REPEAT;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                REPEAT: begin
                    if (!held) begin
                        state_n = IDLE;
                    end else if (cnt == '0) begin
                        pulse_n = 1'b1;
                        cnt_n   = ARR_LOAD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tetris_key_action.sv
// rtl/tetris_key_action.sv - PS/2 held-key report to Tetris game-action pulses
//
// Ports:
//   clk                  - system clock
//   rst                  - asynchronous active-low reset
//   key1_on, key1_code   - slot-1 held report (asynchronous to clk)
//   key2_on, key2_code   - slot-2 held report (asynchronous to clk)
//   act_left/right/soft_drop         - auto-repeating move pulses
//   act_hard_drop/rot_cw/rot_ccw/start - one-shot pulses
//   paused               - pause state
// Optional feature macro: TETRIS_PAUSE_TOGGLE_EN (act_start toggles paused,
// which suppresses all other actions). Undefined: paused is tied to 0.
// Pulse latency: 4 clk cycles after the first edge sampling a steady input.
module tetris_key_action
    import tetris_key_pkg::*;
#(
    parameter int DAS_CYCLES = 20,
    parameter int ARR_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1_on,
    input  logic [7:0] key1_code,
    input  logic       key2_on,
    input  logic [7:0] key2_code,
    output logic       act_left,
    output logic       act_right,
    output logic       act_soft_drop,
    output logic       act_hard_drop,
    output logic       act_rot_cw,
    output logic       act_rot_ccw,
    output logic       act_start,
    output logic       paused
);

    logic [8:0] k1_s1, k1_s2, k1_s3;
    logic [8:0] k2_s1, k2_s2, k2_s3;
    logic [6:0] dec1, dec2;
    logic [6:0] held;
    logic [3:0] os_held_q;
    logic [3:0] os_press;
    logic [3:0] os_pulse;
    logic [2:0] rpt_pulse;
    logic       paused_r;

    // Whole 9-bit slots go through three stages; a slot is only trusted when
    // s2 == s3, which filters out samples caught mid-transition with skewed bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k1_s1 <= '0;
            k1_s2 <= '0;
            k1_s3 <= '0;
            k2_s1 <= '0;
            k2_s2 <= '0;
            k2_s3 <= '0;
            dec1  <= '0;
            dec2  <= '0;
        end else begin
            k1_s1 <= {key1_on, key1_code};
            k1_s2 <= k1_s1;
            k1_s3 <= k1_s2;
            k2_s1 <= {key2_on, key2_code};
            k2_s2 <= k2_s1;
            k2_s3 <= k2_s2;
            if (k1_s2 == k1_s3) dec1 <= decode_slot(k1_s3);
            if (k2_s2 == k2_s3) dec2 <= decode_slot(k2_s3);
        end
    end

    assign held = dec1 | dec2;

    // One-shot keys: bits 0..3 map to hard, rot_cw, rot_ccw, start.
    // Both rotate-cw codes share one held bit, so a second cw key adds no edge.
    assign os_press = held[H_START:H_HARD] & ~os_held_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_held_q <= '0;
            os_pulse  <= '0;
        end else begin
            os_held_q <= held[H_START:H_HARD];
            os_pulse  <= os_press;
        end
    end

`ifdef TETRIS_PAUSE_TOGGLE_EN
    // Toggles on the same edge that registers the start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paused_r <= 1'b0;
        end else if (os_press[3]) begin
            paused_r <= ~paused_r;
        end
    end
`else
    assign paused_r = 1'b0;
`endif

    key_repeat_timer #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_left (
        .clk(clk), .rst(rst), .held(held[H_LEFT]), .en(~paused_r), .pulse(rpt_pulse[0])
    );

    key_repeat_timer #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_right (
        .clk(clk), .rst(rst), .held(held[H_RIGHT]), .en(~paused_r), .pulse(rpt_pulse[1])
    );

    key_repeat_timer #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_soft (
        .clk(clk), .rst(rst), .held(held[H_SOFT]), .en(~paused_r), .pulse(rpt_pulse[2])
    );

    // Masking by paused also hides a pulse registered on the pausing edge.
    assign act_left      = rpt_pulse[0] & ~paused_r;
    assign act_right     = rpt_pulse[1] & ~paused_r;
    assign act_soft_drop = rpt_pulse[2] & ~paused_r;
    assign act_hard_drop = os_pulse[0] & ~paused_r;
    assign act_rot_cw    = os_pulse[1] & ~paused_r;
    assign act_rot_ccw   = os_pulse[2] & ~paused_r;
    assign act_start     = os_pulse[3];
    assign paused        = paused_r;

endmodule

// File: tb/tb_tetris_key_action.sv
// tb/tb_tetris_key_action.sv - scoreboard bench for tetris_key_action (DAS=5, ARR=2)
module tb_tetris_key_action;

    localparam int DAS = 5;
    localparam int ARR = 2;
    localparam int LAT = 5;   // drive at negedge of cycle t -> pulse seen at negedge of t+5
    localparam logic [6:0] V_LEFT  = 7'b0000001;
    localparam logic [6:0] V_RIGHT = 7'b0000010;
    localparam logic [6:0] V_SOFT  = 7'b0000100;
    localparam logic [6:0] V_HARD  = 7'b0001000;
    localparam logic [6:0] V_CW    = 7'b0010000;
    localparam logic [6:0] V_CCW   = 7'b0100000;
    localparam logic [6:0] V_START = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key1_on = 1'b0, key2_on = 1'b0;
    logic [7:0] key1_code = 8'hF0, key2_code = 8'hF0;
    logic       act_left, act_right, act_soft_drop, act_hard_drop;
    logic       act_rot_cw, act_rot_ccw, act_start, paused;
    logic [6:0] act;

    tetris_key_action #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR)) dut (
        .clk(clk), .rst(rst),
        .key1_on(key1_on), .key1_code(key1_code),
        .key2_on(key2_on), .key2_code(key2_code),
        .act_left(act_left), .act_right(act_right), .act_soft_drop(act_soft_drop),
        .act_hard_drop(act_hard_drop), .act_rot_cw(act_rot_cw), .act_rot_ccw(act_rot_ccw),
        .act_start(act_start), .paused(paused)
    );

    always #5 clk = ~clk;

    assign act = {act_start, act_rot_ccw, act_rot_cw, act_hard_drop,
                  act_soft_drop, act_right, act_left};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] v;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] exp_map[int];
    int         n_checks = 0;
    int         n_fails  = 0;

    // Scoreboard: every nonzero action vector must match the next expected event.
    always @(negedge clk) begin
        if (act !== 7'd0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_pulse: cycle %0d act %b, required no pulse", cyc, act);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.c != cyc || e.v !== act) begin
                    n_fails++;
                    $display("FAIL pulse_schedule: cycle %0d act %b, required cycle %0d act %b",
                             cyc, act, e.c, e.v);
                end
            end
        end
    end

    function automatic void add_exp(input int c, input logic [6:0] v);
        if (exp_map.exists(c)) exp_map[c] = exp_map[c] | v;
        else exp_map[c] = v;
    endfunction

    // Key pressed at drive cycle t_on, released at drive cycle t_off: the last
    // edge still seeing it held is t_off+4.
    function automatic void add_repeat(input int t_on, input int t_off, input logic [6:0] v);
        int c;
        int last;
        last = t_off + LAT - 1;
        c = t_on + LAT;
        if (c <= last) add_exp(c, v);
        c = c + DAS;
        while (c <= last) begin
            add_exp(c, v);
            c = c + ARR;
        end
    endfunction

    task automatic commit();
        foreach (exp_map[k]) exp_q.push_back('{k, exp_map[k]});
        exp_map.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic o1, input logic [7:0] c1, input logic o2, input logic [7:0] c2);
        key1_on = o1; key1_code = c1; key2_on = o2; key2_code = c2;
    endtask

    task automatic check_drained(input string name);
        step(8);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL %s_drained: %0d expected pulses never seen (next cycle %0d), required 0",
                     name, exp_q.size(), exp_q[0].c);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(3);
        n_checks++;
        if (act !== 7'd0) begin
            n_fails++;
            $display("FAIL reset_act: act %b, required 0000000", act);
        end
        n_checks++;
        if (paused !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_paused: paused %b, required 0", paused);
        end
        rst = 1'b1;
        step(3);
    endtask

    task automatic test_left_repeat();
        int t0;
        t0 = cyc;
        add_repeat(t0, t0 + 20, V_LEFT);
        commit();
        drive(1'b1, 8'h6B, 1'b0, 8'hF0);
        step(20);
        drive(1'b0, 8'h6B, 1'b0, 8'hF0);
        check_drained("left_repeat");
    endtask

    task automatic test_oneshot();
        int t0;
        t0 = cyc;
        add_exp(t0 + LAT, V_CCW);
        add_exp(t0 + 40 + LAT, V_CCW);
        add_exp(t0 + 60 + LAT, V_CW);
        add_exp(t0 + 90 + LAT, V_HARD);
        commit();
        drive(1'b0, 8'hF0, 1'b1, 8'h1A);
        step(30);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        step(10);
        drive(1'b0, 8'hF0, 1'b1, 8'h1A);
        step(15);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        step(5);
        drive(1'b1, 8'h12, 1'b0, 8'hF0);
        step(10);
        drive(1'b1, 8'h12, 1'b1, 8'h22);
        step(12);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        step(8);
        drive(1'b1, 8'h75, 1'b0, 8'hF0);
        step(12);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        check_drained("oneshot");
    endtask

    task automatic test_soft_with_rotate();
        int t0;
        t0 = cyc;
        add_repeat(t0, t0 + 30, V_SOFT);
        add_exp(t0 + 9 + LAT, V_CW);   // lands on the soft-drop pulse at +14
        commit();
        drive(1'b1, 8'h72, 1'b0, 8'hF0);
        step(9);
        drive(1'b1, 8'h72, 1'b1, 8'h22);
        step(21);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        check_drained("soft_rotate");
    endtask

    task automatic test_code_swap();
        int t0;
        t0 = cyc;
        add_repeat(t0, t0 + 12, V_LEFT);
        add_repeat(t0 + 12, t0 + 27, V_RIGHT);
        commit();
        drive(1'b1, 8'h6B, 1'b0, 8'hF0);
        step(12);
        drive(1'b1, 8'h74, 1'b0, 8'hF0);
        step(15);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        check_drained("code_swap");
    endtask

    task automatic test_glitch();
        drive(1'b1, 8'hF0, 1'b0, 8'hF0);
        step(6);
        drive(1'b1, 8'h6B, 1'b0, 8'hF0);
        step(1);
        drive(1'b1, 8'hF0, 1'b0, 8'hF0);
        step(12);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        check_drained("glitch");
    endtask

    task automatic test_reset_mid_repeat();
        int t0;
        int tr;
        t0 = cyc;
        add_exp(t0 + LAT, V_LEFT);
        add_exp(t0 + LAT + DAS, V_LEFT);
        commit();
        drive(1'b1, 8'h6B, 1'b0, 8'hF0);
        step(10);                      // act_left is high in this cycle
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (act !== 7'd0) begin
            n_fails++;
            $display("FAIL async_reset_act: act %b, required 0000000", act);
        end
        step(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL pre_reset_pulses: %0d missing, required 0", exp_q.size());
            exp_q.delete();
        end
        tr = cyc;
        add_repeat(tr, tr + 14, V_LEFT);
        commit();
        rst = 1'b1;
        step(14);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        check_drained("reset_mid_repeat");
    endtask

`ifdef TETRIS_PAUSE_TOGGLE_EN
    task automatic test_start_pause();
        int t0;
        t0 = cyc;
        add_exp(t0 + LAT, V_START);
        add_exp(t0 + 50 + LAT, V_START);
        commit();
        drive(1'b1, 8'h5A, 1'b0, 8'hF0);
        step(10);
        n_checks++;
        if (paused !== 1'b1) begin
            n_fails++;
            $display("FAIL pause_set: paused %b, required 1", paused);
        end
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        step(10);
        drive(1'b1, 8'h6B, 1'b0, 8'hF0);
        step(20);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        step(10);
        drive(1'b0, 8'hF0, 1'b1, 8'h5A);
        step(10);
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        step(10);
        n_checks++;
        if (paused !== 1'b0) begin
            n_fails++;
            $display("FAIL pause_clear: paused %b, required 0", paused);
        end
        check_drained("start_pause");
    endtask
`else
    task automatic test_start_pause();
        int t0;
        t0 = cyc;
        add_exp(t0 + LAT, V_START);
        commit();
        drive(1'b1, 8'h5A, 1'b0, 8'hF0);
        step(12);
        n_checks++;
        if (paused !== 1'b0) begin
            n_fails++;
            $display("FAIL paused_tied: paused %b, required 0", paused);
        end
        drive(1'b0, 8'hF0, 1'b0, 8'hF0);
        check_drained("start_oneshot");
    endtask
`endif

    initial begin
        test_reset();
        test_left_repeat();
        test_oneshot();
        test_soft_with_rotate();
        test_code_swap();
        test_glitch();
        test_reset_mid_repeat();
        test_start_pause();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
